jtdsp16_sio_tx: RTL and testbench
=================================

# jtdsp16_sio_tx

Parametrised serial output unit for the DSP16 core. It takes the place of the fixed 16-bit, single-buffer output path of the serial I/O block. It adds configurable word width, a write FIFO, a multi-channel serial address and selectable bit order. It sits between the CPU register-write path (`long_imm`/SIO load strobes) and the `sdo`/`ock`/`old`/`sadd`/`ose` pins, and runs on the core's divided clock enable.

## Interface
Parameters:
- `DW`, 16 — serial word width in bits; range 4..32.
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `CHW`, 1 — channel address width in bits, shifted out on `sadd`; ≥1.
- `CKDIV`, 2 — `cen` pulses per `ock` half-period; ≥1.

Ports:
- `clk` in 1 — single clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `cen` in 1 — clock enable (`cen2` in the core).
- `wr_en` in 1 — push request; sampled on any `clk`, independent of `cen`.
- `wr_data` in DW — word to transmit.
- `wr_ch` in CHW — channel address attached to the word.
- `msb_first` in 1 — bit order. 1 = MSB first. Sampled at frame start.
- `doen` in 1 — data output enable.
- `full` out 1 — FIFO holds DEPTH entries.
- `obe` out 1 — output buffer empty: FIFO empty.
- `level` out $clog2(DEPTH)+1 — FIFO occupancy.
- `ock` out 1 — serial output clock.
- `sdo` out 1 — serial data.
- `old` out 1 — output load: high for the first bit period of each frame.
- `sadd` out 1 — serial channel address.
- `ose` out 1 — output shift register empty.

## Operation
- **FIFO.** Each entry is {ch, data}. A push succeeds when `wr_en && !full`; a push while full is dropped silently.
  - `full` comes from registered occupancy. A pop in the same cycle does not make room for a push.
- **Bit clock.** A tick counter counts `cen` pulses. At count CKDIV-1 it wraps and `ock` toggles. A "fall" is the `clk` cycle in which `ock` goes 1→0. All shifter updates happen only on falls.
- **FSM states:** IDLE, SHIFT.
  - IDLE, at a fall, with `!obe && doen`: pop the head entry into the shift and address registers, latch `msb_first`, and go to SHIFT with bit counter = 0. `old`=1, `ose`=0, `sdo` = first bit, `sadd` = ch[0].
  - SHIFT, at each fall: bit counter +1 and the next bit goes to `sdo`. `old`=0 after the first bit.
    - `sadd` = ch[k] for bit k < CHW, otherwise 0. With CHW > DW, the excess address bits are truncated.
  - SHIFT, at the fall after bit DW-1: if `!obe && doen`, start the next frame immediately with no gap (same actions as IDLE start). Otherwise go to IDLE with `ose`=1, `sdo`=0, `sadd`=0.
- **Output enable.** `doen` low blocks new frame starts and forces `sdo`=0. A frame already in progress keeps shifting.
- **Bit order.** LSB-first sends data[0] first.

## Timing
- **Reset values:** `ock`=0, `sdo`=0, `old`=0, `sadd`=0, `ose`=1, `obe`=1, `full`=0, `level`=0, FSM=IDLE, tick counter=0, FIFO pointers=0.
- **`rst_n` low mid-frame:** aborts the frame and flushes the FIFO on that cycle.
- **FIFO flags:** `level`, `full` and `obe` update one `clk` after a push or pop. Simultaneous push and pop leaves `level` unchanged.
- **`ock` period:** 2·CKDIV `cen` pulses. A frame lasts DW `ock` periods.
- **Start latency:** a word pushed into an empty FIFO with the shifter idle appears on `sdo` at the first fall at least one `clk` after the push.
- **Bit order on the wire:** `sdo` changes only on falls, so the external receiver samples on the `ock` rise.

## Structure
- Shared package `jtdsp16_pkg`: FSM state enum (`SIO_IDLE`, `SIO_SHIFT`), a default-width constant, and a `clog2` helper if the toolchain needs one.
- One natural sub-module, `jtdsp16_fifo` (parametrised by DW+CHW and DEPTH, with push/pop/full/empty/level). Tick counter, FSM and shifter stay in the top module.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs at their reset values, and `ock` stays 0 with `cen` running.
- **MSB-first word:** DW=16, CKDIV=2, `msb_first`=1, push 16'hA5C3, ch=1 → `sdo` bits 1010 0101 1100 0011 on successive falls, `old` high for bit 0 only, `sadd`=1 on bit 0, then `ose`=1.
- **LSB-first word:** push 16'h0001 with `msb_first`=0 → `sdo`=1 on the first bit, 0 on the remaining 15.
- **Back-to-back and overflow:** push 5 words with DEPTH=4 while `doen`=0 → `full`=1 after 4 pushes, the 5th is dropped, `level`=4. Then raise `doen` → exactly 4 contiguous frames, with `old` pulsing every 16 `ock` periods and no idle gap.
- **Reset mid-frame:** assert `rst_n`=0 at bit 7 of a frame, with 2 words queued → next cycle `sdo`=0, `ose`=1, `obe`=1, `level`=0. After release, nothing is transmitted.
- **Generics:** DW=8, CKDIV=1, CHW=2, ch=2'b10 → `ock` period = 2 `cen`, frame = 8 `ock` periods, and `sadd` sequence 0,1,0,0,0,0,0,0.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// rtl/jtdsp16_pkg.sv - shared types and constants for the DSP16 serial output unit
package jtdsp16_pkg;

   typedef enum logic {
      SIO_IDLE  = 1'b0,
      SIO_SHIFT = 1'b1
   } sio_state_e;

   localparam int SIO_DW_DEFAULT = 16;

endpackage

// File: rtl/jtdsp16_fifo.sv
// rtl/jtdsp16_fifo.sv - write FIFO holding {channel, data} entries for the serial output unit
module jtdsp16_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   level_q;
   logic          do_push;
   logic          do_pop;

   // Flags come from the registered level, so a pop never frees a slot for a same-cycle push.
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/jtdsp16_sio_tx.sv
// rtl/jtdsp16_sio_tx.sv - parametrised DSP16 serial output unit with FIFO, channel address and bit order
module jtdsp16_sio_tx
   import jtdsp16_pkg::*;
#(
   parameter int DW    = SIO_DW_DEFAULT,
   parameter int DEPTH = 4,
   parameter int CHW   = 1,
   parameter int CKDIV = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic                   wr_en,
   input  logic [DW-1:0]          wr_data,
   input  logic [CHW-1:0]         wr_ch,
   input  logic                   msb_first,
   input  logic                   doen,
   output logic                   full,
   output logic                   obe,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ock,
   output logic                   sdo,
   output logic                   old,
   output logic                   sadd,
   output logic                   ose
);
   localparam int            TW        = (CKDIV > 1) ? $clog2(CKDIV) : 1;
   localparam int            BW        = $clog2(DW);
   localparam logic [TW-1:0] TICK_LAST = TW'(CKDIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

   sio_state_e        state_q;
   logic [TW-1:0]     tick_q;
   logic [BW-1:0]     bit_q;
   logic [DW-1:0]     sh_q;
   logic [CHW-1:0]    ch_q;
   logic              ock_q, sdo_q, old_q, sadd_q, ose_q, msb_q;

   logic [DW+CHW-1:0] head_d;
   logic [DW-1:0]     head_data_d;
   logic [CHW-1:0]    head_ch_d;
   logic              tick_wrap, fall, frame_end, start;

   assign {head_ch_d, head_data_d} = head_d;
   assign tick_wrap = cen && (tick_q == TICK_LAST);
   assign fall      = tick_wrap && ock_q;
   assign frame_end = (state_q == SIO_IDLE) || (bit_q == BIT_LAST);
   // A start at the end of a frame chains the next word with no idle bit period.
   assign start     = fall && frame_end && !obe && doen;

   jtdsp16_fifo #(
      .W     (DW + CHW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .wdata ({wr_ch, wr_data}),
      .pop   (start),
      .rdata (head_d),
      .full  (full),
      .empty (obe),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SIO_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         ch_q    <= '0;
         ock_q   <= 1'b0;
         sdo_q   <= 1'b0;
         old_q   <= 1'b0;
         sadd_q  <= 1'b0;
         ose_q   <= 1'b1;
         msb_q   <= 1'b0;
      end else begin
         if (cen)       tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
         if (tick_wrap) ock_q  <= ~ock_q;
         if (start) begin
            state_q <= SIO_SHIFT;
            bit_q   <= '0;
            msb_q   <= msb_first;
            old_q   <= 1'b1;
            ose_q   <= 1'b0;
            sdo_q   <= msb_first ? head_data_d[DW-1] : head_data_d[0];
            sh_q    <= msb_first ? {head_data_d[DW-2:0], 1'b0} : {1'b0, head_data_d[DW-1:1]};
            sadd_q  <= head_ch_d[0];
            ch_q    <= head_ch_d >> 1;
         end else if (fall && state_q == SIO_SHIFT) begin
            if (bit_q == BIT_LAST) begin
               state_q <= SIO_IDLE;
               old_q   <= 1'b0;
               ose_q   <= 1'b1;
               sdo_q   <= 1'b0;
               sadd_q  <= 1'b0;
            end else begin
               bit_q   <= bit_q + 1'b1;
               old_q   <= 1'b0;
               sdo_q   <= msb_q ? sh_q[DW-1] : sh_q[0];
               sh_q    <= msb_q ? {sh_q[DW-2:0], 1'b0} : {1'b0, sh_q[DW-1:1]};
               sadd_q  <= ch_q[0];
               ch_q    <= ch_q >> 1;
            end
         end
      end
   end

   assign ock  = ock_q;
   assign sdo  = sdo_q & doen;
   assign old  = old_q;
   assign sadd = sadd_q;
   assign ose  = ose_q;

endmodule

// File: tb/tb_jtdsp16_sio_tx.sv
// tb/tb_jtdsp16_sio_tx.sv - self-checking bench for jtdsp16_sio_tx against a bit-sequence model
module tb_jtdsp16_sio_tx;

   typedef struct packed {
      logic        sdo;
      logic        old;
      logic        sadd;
      logic        ose;
      int unsigned dcen;
   } rec_t;

   logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0;

   logic        wr_en_a = 1'b0, wr_ch_a = 1'b0, msb_a = 1'b1, doen_a = 1'b0;
   logic [15:0] wr_data_a = '0;
   logic        full_a, obe_a, ock_a, sdo_a, old_a, sadd_a, ose_a;
   logic [2:0]  level_a;

   logic        wr_en_b = 1'b0, msb_b = 1'b1, doen_b = 1'b0;
   logic [7:0]  wr_data_b = '0;
   logic [1:0]  wr_ch_b = '0;
   logic        full_b, obe_b, ock_b, sdo_b, old_b, sadd_b, ose_b;
   logic [2:0]  level_b;

   int tests = 0, fails = 0;
   rec_t rec_a[$], rec_b[$];
   int unsigned cen_total = 0, last_a = 0, last_b = 0;
   logic ock_pa = 1'b0, ock_pb = 1'b0;

   jtdsp16_sio_tx #(.DW(16), .DEPTH(4), .CHW(1), .CKDIV(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en_a), .wr_data(wr_data_a), .wr_ch(wr_ch_a),
      .msb_first(msb_a), .doen(doen_a), .full(full_a), .obe(obe_a), .level(level_a),
      .ock(ock_a), .sdo(sdo_a), .old(old_a), .sadd(sadd_a), .ose(ose_a));

   jtdsp16_sio_tx #(.DW(8), .DEPTH(4), .CHW(2), .CKDIV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .cen(cen), .wr_en(wr_en_b), .wr_data(wr_data_b), .wr_ch(wr_ch_b),
      .msb_first(msb_b), .doen(doen_b), .full(full_b), .obe(obe_b), .level(level_b),
      .ock(ock_b), .sdo(sdo_b), .old(old_b), .sadd(sadd_b), .ose(ose_b));

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      cen = ($urandom_range(0, 3) != 0);
   end

   always @(posedge clk) cen_total <= cen_total + cen;

   // One record per ock fall: the shifter outputs valid for the following bit period.
   always @(negedge clk) begin
      if (ock_pa && !ock_a) begin
         rec_a.push_back('{sdo_a, old_a, sadd_a, ose_a, cen_total - last_a});
         last_a <= cen_total;
      end
      if (ock_pb && !ock_b) begin
         rec_b.push_back('{sdo_b, old_b, sadd_b, ose_b, cen_total - last_b});
         last_b <= cen_total;
      end
      ock_pa <= ock_a;
      ock_pb <= ock_b;
   end

   function automatic logic exp_bit(input logic [31:0] d, input logic msb, input int dw, input int k);
      return msb ? d[dw-1-k] : d[k];
   endfunction

   function automatic logic exp_sadd(input logic [1:0] ch, input int chw, input int k);
      return (k < chw) ? ch[k] : 1'b0;
   endfunction

   task automatic push_a(input logic [15:0] d, input logic ch);
      @(negedge clk); wr_en_a = 1'b1; wr_data_a = d; wr_ch_a = ch;
      @(negedge clk); wr_en_a = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] d, input logic [1:0] ch);
      @(negedge clk); wr_en_b = 1'b1; wr_data_b = d; wr_ch_b = ch;
      @(negedge clk); wr_en_b = 1'b0;
   endtask

   task automatic wait_start(input bit sel_b, input int need, input int budget, output int s);
      int c = 0;
      s = -1;
      while (c < budget) begin
         @(posedge clk); c++;
         if (s < 0) begin
            if (sel_b) begin foreach (rec_b[i]) if (s < 0 && rec_b[i].old) s = i; end
            else       begin foreach (rec_a[i]) if (s < 0 && rec_a[i].old) s = i; end
         end
         if (s >= 0 && (sel_b ? rec_b.size() : rec_a.size()) >= s + need) break;
      end
      if (s >= 0 && (sel_b ? rec_b.size() : rec_a.size()) < s + need) s = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         tests++;
         if ({ock_a, ock_b} !== 2'b00) begin
            fails++; $display("FAIL reset_ock: got %b expected 00", {ock_a, ock_b});
         end
      end
      tests++;
      if ({sdo_a, old_a, sadd_a, ose_a, obe_a, full_a, level_a} !== 10'b0001_10_000) begin
         fails++; $display("FAIL reset_a: got %b expected 0001100000", {sdo_a, old_a, sadd_a, ose_a, obe_a, full_a, level_a});
      end
      tests++;
      if ({sdo_b, old_b, sadd_b, ose_b, obe_b, full_b, level_b} !== 10'b0001_10_000) begin
         fails++; $display("FAIL reset_b: got %b expected 0001100000", {sdo_b, old_b, sadd_b, ose_b, obe_b, full_b, level_b});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single_a(input string name, input logic [15:0] d, input logic ch, input logic msb);
      int s;
      logic [3:0] exp;
      msb_a = msb; doen_a = 1'b1; rec_a.delete();
      push_a(d, ch);
      wait_start(1'b0, 17, 3000, s);
      tests++;
      if (s < 0) begin
         fails++; $display("FAIL %s_timeout: got no frame expected 17 bit periods", name);
         return;
      end
      for (int k = 0; k < 16; k++) begin
         exp = {exp_bit({16'h0, d}, msb, 16, k), k == 0, exp_sadd({1'b0, ch}, 1, k), 1'b0};
         tests++;
         if ({rec_a[s+k].sdo, rec_a[s+k].old, rec_a[s+k].sadd, rec_a[s+k].ose} !== exp) begin
            fails++; $display("FAIL %s_bit%0d sdo/old/sadd/ose: got %b expected %b", name, k,
                              {rec_a[s+k].sdo, rec_a[s+k].old, rec_a[s+k].sadd, rec_a[s+k].ose}, exp);
         end
         if (k > 0) begin
            tests++;
            if (rec_a[s+k].dcen !== 4) begin
               fails++; $display("FAIL %s_period%0d: got %0d cen expected 4", name, k, rec_a[s+k].dcen);
            end
         end
      end
      tests++;
      if ({rec_a[s+16].sdo, rec_a[s+16].old, rec_a[s+16].sadd, rec_a[s+16].ose} !== 4'b0001) begin
         fails++; $display("FAIL %s_end: got %b expected 0001", name,
                           {rec_a[s+16].sdo, rec_a[s+16].old, rec_a[s+16].sadd, rec_a[s+16].ose});
      end
   endtask

   task automatic test_msb_first;
      test_single_a("msb", 16'hA5C3, 1'b1, 1'b1);
   endtask

   task automatic test_lsb_first;
      test_single_a("lsb", 16'h0001, 1'b0, 1'b0);
   endtask

   task automatic test_random_words;
      for (int r = 0; r < 4; r++) begin
         test_single_a($sformatf("rand%0d", r), 16'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] words[$];
      logic        chans[$];
      logic [15:0] d;
      logic        c, msb;
      logic [3:0]  exp;
      int          s, w, k;
      msb = 1'($urandom); msb_a = msb; doen_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = 16'($urandom); c = 1'($urandom);
         if (words.size() < 4) begin words.push_back(d); chans.push_back(c); end
         push_a(d, c);
         tests++;
         if ({full_a, level_a} !== {words.size() == 4, 3'(words.size())}) begin
            fails++; $display("FAIL fill%0d full/level: got %b/%0d expected %b/%0d", i, full_a, level_a,
                              words.size() == 4, words.size());
         end
      end
      rec_a.delete();
      @(negedge clk); doen_a = 1'b1;
      wait_start(1'b0, 65, 5000, s);
      tests++;
      if (s < 0) begin
         fails++; $display("FAIL b2b_timeout: got no run expected 65 bit periods");
         return;
      end
      for (int i = 0; i < 64; i++) begin
         w = i / 16; k = i % 16;
         exp = {exp_bit({16'h0, words[w]}, msb, 16, k), k == 0, exp_sadd({1'b0, chans[w]}, 1, k), 1'b0};
         tests++;
         if ({rec_a[s+i].sdo, rec_a[s+i].old, rec_a[s+i].sadd, rec_a[s+i].ose} !== exp ||
             (i > 0 && rec_a[s+i].dcen !== 4)) begin
            fails++; $display("FAIL b2b_w%0d_bit%0d: got %b/%0d cen expected %b/4 cen", w, k,
                              {rec_a[s+i].sdo, rec_a[s+i].old, rec_a[s+i].sadd, rec_a[s+i].ose}, rec_a[s+i].dcen, exp);
         end
      end
      tests++;
      if ({rec_a[s+64].ose, rec_a[s+64].sdo, obe_a, level_a} !== 6'b10_1_000) begin
         fails++; $display("FAIL b2b_end ose/sdo/obe/level: got %b expected 101000",
                           {rec_a[s+64].ose, rec_a[s+64].sdo, obe_a, level_a});
      end
   endtask

   task automatic test_generics;
      logic [7:0] d;
      logic [1:0] c;
      logic       msb;
      logic [3:0] exp;
      int         s;
      for (int r = 0; r < 3; r++) begin
         d = 8'($urandom); c = (r == 0) ? 2'b10 : 2'($urandom); msb = 1'($urandom);
         msb_b = msb; doen_b = 1'b1; rec_b.delete();
         push_b(d, c);
         wait_start(1'b1, 9, 2000, s);
         tests++;
         if (s < 0) begin
            fails++; $display("FAIL gen%0d_timeout: got no frame expected 9 bit periods", r);
            continue;
         end
         for (int k = 0; k < 8; k++) begin
            exp = {exp_bit({24'h0, d}, msb, 8, k), k == 0, exp_sadd(c, 2, k), 1'b0};
            tests++;
            if ({rec_b[s+k].sdo, rec_b[s+k].old, rec_b[s+k].sadd, rec_b[s+k].ose} !== exp ||
                (k > 0 && rec_b[s+k].dcen !== 2)) begin
               fails++; $display("FAIL gen%0d_bit%0d: got %b/%0d cen expected %b/2 cen", r, k,
                                 {rec_b[s+k].sdo, rec_b[s+k].old, rec_b[s+k].sadd, rec_b[s+k].ose}, rec_b[s+k].dcen, exp);
            end
         end
         tests++;
         if ({rec_b[s+8].sdo, rec_b[s+8].old, rec_b[s+8].sadd, rec_b[s+8].ose} !== 4'b0001) begin
            fails++; $display("FAIL gen%0d_end: got %b expected 0001", r,
                              {rec_b[s+8].sdo, rec_b[s+8].old, rec_b[s+8].sadd, rec_b[s+8].ose});
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      int s, bad;
      msb_a = 1'($urandom); doen_a = 1'b1; rec_a.delete();
      for (int i = 0; i < 3; i++) push_a(16'($urandom) | 16'h0101, 1'($urandom));
      wait_start(1'b0, 8, 3000, s);
      tests++;
      if (s < 0) begin
         fails++; $display("FAIL midrst_timeout: got no frame expected bit 7");
         return;
      end
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({sdo_a, ose_a, obe_a, level_a, old_a, ock_a} !== 8'b0_1_1_000_0_0) begin
         fails++; $display("FAIL midrst_state sdo/ose/obe/level/old/ock: got %b expected 01100000",
                           {sdo_a, ose_a, obe_a, level_a, old_a, ock_a});
      end
      @(negedge clk); rst_n = 1'b1; rec_a.delete();
      repeat (400) @(posedge clk);
      bad = 0;
      foreach (rec_a[i]) if (rec_a[i].old || !rec_a[i].ose || rec_a[i].sdo) bad++;
      tests++;
      if (bad != 0 || rec_a.size() < 10 || obe_a !== 1'b1) begin
         fails++; $display("FAIL midrst_quiet: got %0d active of %0d periods obe=%b expected 0 active obe=1",
                           bad, rec_a.size(), obe_a);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_random_words();
      test_back_to_back();
      test_generics();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
